// File: rtl/zframe_scanout.sv
// Frame-buffer scan-out: reads the frame linearly in 4-pixel bursts into a small FIFO
// and hands one pixel per request to the TFT timing generator, blanking on underflow.
module zframe_scanout #(
  parameter int          FRAME_PIXELS = 384000,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BLANK_COLOR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        iFrame_Start,
  output logic [23:0] oSDRAM_Rd_Addr,
  output logic        oSDRAM_Rd_Req,
  input  logic        iSDRAM_Rd_Done,
  input  logic [15:0] iSDRAM_Data1,
  input  logic [15:0] iSDRAM_Data2,
  input  logic [15:0] iSDRAM_Data3,
  input  logic [15:0] iSDRAM_Data4,
  input  logic        iPix_Req,
  output logic [15:0] oPix_Data,
  output logic        oPix_Valid,
  output logic        oUnderflow
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [23:0]     FRAME_END  = 24'(FRAME_PIXELS);
  localparam logic [CW-1:0]   FILL_LIMIT = CW'(FIFO_DEPTH - 4);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REQ, S_GAP} state_t;

  state_t          state_reg, state_next;
  logic [23:0]     addr_reg;
  logic            discard_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [15:0]     push_data [4];
  logic [AW-1:0]   wr_idx [4];
  logic            flush, issue, rd_done, push, pop, starve;

  // Disabling behaves like a continuous frame restart: FIFO and address held clear.
  assign flush   = iFrame_Start | ~en;
  assign issue   = en & ~iFrame_Start & (addr_reg < FRAME_END) & (count_reg <= FILL_LIMIT);
  assign rd_done = (state_reg == S_REQ) & iSDRAM_Rd_Done;
  assign push    = rd_done & ~discard_reg & ~flush;
  assign pop     = iPix_Req & ~flush & (count_reg != '0);
  assign starve  = iPix_Req & ~flush & (count_reg == '0);

  assign push_data[0] = iSDRAM_Data1;
  assign push_data[1] = iSDRAM_Data2;
  assign push_data[2] = iSDRAM_Data3;
  assign push_data[3] = iSDRAM_Data4;

  for (genvar gi = 0; gi < 4; gi++) begin : g_widx
    assign wr_idx[gi] = wr_ptr_reg + AW'(gi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (en) state_next = S_CHECK;
      S_CHECK: begin
        if (!en)        state_next = S_IDLE;
        else if (issue) state_next = S_REQ;
      end
      S_REQ:   if (iSDRAM_Rd_Done) state_next = en ? S_GAP : S_IDLE;
      S_GAP:   state_next = en ? S_CHECK : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    oSDRAM_Rd_Req = 1'b0;
    if (state_reg == S_REQ) oSDRAM_Rd_Req = 1'b1;
  end

  always_comb begin
    count_next = count_reg;
    if (push) count_next = count_next + CW'(4);
    if (pop)  count_next = count_next - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < 4; k++) mem[wr_idx[k]] <= push_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg       <= '0;
      oSDRAM_Rd_Addr <= '0;
      discard_reg    <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      if (state_reg == S_CHECK && issue) oSDRAM_Rd_Addr <= addr_reg;
      // A read already in flight when the frame restarts must still complete, but its data is stale.
      if (state_reg == S_REQ && !iSDRAM_Rd_Done && flush) discard_reg <= 1'b1;
      else if (state_reg != S_REQ || iSDRAM_Rd_Done)     discard_reg <= 1'b0;
      if (flush) begin
        addr_reg   <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) begin
          addr_reg   <= addr_reg + 24'd4;
          wr_ptr_reg <= wr_ptr_reg + AW'(4);
        end
        if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oPix_Data  <= BLANK_COLOR;
      oPix_Valid <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      oPix_Valid <= iPix_Req;
      if (iPix_Req) oPix_Data <= pop ? mem[rd_ptr_reg] : BLANK_COLOR;
      if (iFrame_Start) oUnderflow <= 1'b0;
      else if (starve)  oUnderflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zframe_scanout.sv
// Scoreboard bench for zframe_scanout with a 32-pixel test frame and an address-echo memory model.
module tb_zframe_scanout;

  localparam int          FP    = 32;
  localparam logic [15:0] BLANK = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst_n, en, iFrame_Start, iPix_Req;
  logic [23:0] oSDRAM_Rd_Addr;
  logic        oSDRAM_Rd_Req, iSDRAM_Rd_Done;
  logic [15:0] iSDRAM_Data1, iSDRAM_Data2, iSDRAM_Data3, iSDRAM_Data4;
  logic [15:0] oPix_Data;
  logic        oPix_Valid, oUnderflow;

  zframe_scanout #(.FRAME_PIXELS(FP), .FIFO_DEPTH(16), .BLANK_COLOR(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iFrame_Start(iFrame_Start),
    .oSDRAM_Rd_Addr(oSDRAM_Rd_Addr), .oSDRAM_Rd_Req(oSDRAM_Rd_Req),
    .iSDRAM_Rd_Done(iSDRAM_Rd_Done),
    .iSDRAM_Data1(iSDRAM_Data1), .iSDRAM_Data2(iSDRAM_Data2),
    .iSDRAM_Data3(iSDRAM_Data3), .iSDRAM_Data4(iSDRAM_Data4),
    .iPix_Req(iPix_Req), .oPix_Data(oPix_Data), .oPix_Valid(oPix_Valid),
    .oUnderflow(oUnderflow)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_addr[$];
  logic [15:0] exp_pix[$];
  int          lat = 2;
  int          glue_cnt = 0;
  logic        req_q = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Read glue: done after `lat` further cycles of req, data echoes the pixel address.
  initial begin
    iSDRAM_Rd_Done = 1'b0;
    iSDRAM_Data1 = '0; iSDRAM_Data2 = '0; iSDRAM_Data3 = '0; iSDRAM_Data4 = '0;
    forever begin
      @(negedge clk);
      iSDRAM_Rd_Done = 1'b0;
      if (rst_n && oSDRAM_Rd_Req) begin
        if (glue_cnt >= lat) begin
          iSDRAM_Rd_Done = 1'b1;
          iSDRAM_Data1 = oSDRAM_Rd_Addr[15:0];
          iSDRAM_Data2 = oSDRAM_Rd_Addr[15:0] + 16'd1;
          iSDRAM_Data3 = oSDRAM_Rd_Addr[15:0] + 16'd2;
          iSDRAM_Data4 = oSDRAM_Rd_Addr[15:0] + 16'd3;
          glue_cnt = 0;
        end else begin
          glue_cnt++;
        end
      end else begin
        glue_cnt = 0;
      end
    end
  end

  // Read-address monitor: one check per new request.
  always @(negedge clk) begin
    if (rst_n && oSDRAM_Rd_Req && !req_q) begin
      if (exp_addr.size() == 0) chk("rd_addr_unexpected", int'(oSDRAM_Rd_Addr), -1);
      else                      chk("rd_addr", int'(oSDRAM_Rd_Addr), exp_addr.pop_front());
    end
    req_q <= oSDRAM_Rd_Req;
  end

  // Pixel monitor.
  always @(negedge clk) begin
    if (rst_n && oPix_Valid) begin
      if (exp_pix.size() == 0) chk("pix_unexpected", int'(oPix_Data), -1);
      else                     chk("pix", int'(oPix_Data), int'(exp_pix.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix_burst(input int n, input int first, input bit blank);
    for (int i = 0; i < n; i++) begin
      iPix_Req = 1'b1;
      exp_pix.push_back(blank ? BLANK : 16'(first + i));
      @(negedge clk);
    end
    iPix_Req = 1'b0;
  endtask

  task automatic push_addrs(input int first, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(first + 4 * i);
  endtask

  task automatic frame_start();
    iFrame_Start = 1'b1;
    @(negedge clk);
    iFrame_Start = 1'b0;
  endtask

  task automatic wait_req(input int want, input string name);
    int t = 0;
    while (!(oSDRAM_Rd_Req && oSDRAM_Rd_Addr == 24'(want)) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, int'(t < 200), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; iFrame_Start = 1'b0; iPix_Req = 1'b0;
    tick(3);
    chk("rst_req", int'(oSDRAM_Rd_Req), 0);
    chk("rst_addr", int'(oSDRAM_Rd_Addr), 0);
    chk("rst_valid", int'(oPix_Valid), 0);
    chk("rst_uf", int'(oUnderflow), 0);
    chk("rst_pix", int'(oPix_Data), int'(BLANK));
    rst_n = 1'b1;
    tick(1);

    // Prefill: four reads then stall with the FIFO full.
    lat = 2;
    push_addrs(0, 4);
    en = 1'b1;
    tick(60);
    chk("stall_req_low", int'(oSDRAM_Rd_Req), 0);

    // Continuous drain of the whole frame; nothing is read past the frame end.
    lat = 0;
    push_addrs(16, 4);
    pix_burst(FP, 0, 1'b0);
    tick(20);
    chk("frame_end_req_low", int'(oSDRAM_Rd_Req), 0);
    pix_burst(1, 0, 1'b1);
    chk("uf_at_frame_end", int'(oUnderflow), 1);

    // Restart at 0 after frame start; slow read causes blank pixels.
    lat = 40;
    push_addrs(0, 4);
    frame_start();
    chk("uf_cleared_1", int'(oUnderflow), 0);
    pix_burst(10, 0, 1'b1);
    chk("uf_slow_read", int'(oUnderflow), 1);
    tick(45);
    lat = 2;
    tick(40);

    // Frame start while the read at address 8 is in flight.
    lat = 6;
    push_addrs(0, 3);
    frame_start();
    chk("uf_cleared_2", int'(oUnderflow), 0);
    wait_req(8, "wait_req_addr8");
    iFrame_Start = 1'b1;
    iPix_Req = 1'b1;
    exp_pix.push_back(BLANK);
    push_addrs(0, 4);
    @(negedge clk);
    iFrame_Start = 1'b0;
    iPix_Req = 1'b0;
    chk("req_held_after_fs", int'(oSDRAM_Rd_Req), 1);
    chk("uf_fs_with_req", int'(oUnderflow), 0);
    tick(80);
    lat = 0;
    push_addrs(16, 4);
    pix_burst(FP, 0, 1'b0);
    tick(20);
    chk("req_low_2", int'(oSDRAM_Rd_Req), 0);

    // Disable during a request: handshake completes, data dropped, restart at 0.
    lat = 6;
    push_addrs(0, 1);
    frame_start();
    wait_req(0, "wait_req_addr0");
    en = 1'b0;
    tick(20);
    chk("disabled_req_low", int'(oSDRAM_Rd_Req), 0);
    pix_burst(2, 0, 1'b1);
    chk("disabled_no_uf", int'(oUnderflow), 0);
    lat = 0;
    push_addrs(0, 8);
    en = 1'b1;
    tick(30);
    pix_burst(FP, 0, 1'b0);
    tick(20);

    chk("addr_queue_drained", exp_addr.size(), 0);
    chk("pix_queue_drained", exp_pix.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
